// File: rtl/parity_uart_tx.sv
// Serial byte transmitter: start, 8 data bits LSB first, parity, stop.
// One byte per valid/ready handshake; every output is registered.
module parity_uart_tx #(
  parameter int unsigned CLKS_PER_BIT  = 868,
  parameter bit          INVERT_PARITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned DW = 8;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_out_q, tx_out_d;
  logic            tx_ready_q, tx_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            bit_end;

  // Next-state logic; outputs are derived from the next state so they register in step.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_end = (baud_q == BAUD_LAST);

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BW'(1);
    end

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ INVERT_PARITY;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[DW-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tx_out_d = 1'b1;
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = par_d;
      default: tx_out_d = 1'b1;
    endcase

    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == STOP) && (state_d == IDLE);
  end

  // A reset abandons any partial frame; tx_ready stays low until the first edge after release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/parity_uart_tx.md
# parity_uart_tx

Serial transmitter that accepts one byte per valid/ready handshake, appends a parity bit and sends an 11-bit frame on a single line: start, 8 data bits LSB first, parity, stop. It sits directly after the byte-level parity stage in the serial path. The parity bit is the XOR reduction of the 8 data bits, optionally inverted. The block drives the physical TX pin.

## Interface
- CLKS_PER_BIT, 868, clock cycles per serial bit; legal range ≥ 2.
- INVERT_PARITY, 0, 0: parity bit = ^data; 1: parity bit = ~^data.

- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- tx_data  input  8  byte to send; sampled only on handshake.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  block can accept a byte; registered.
- tx_out  output  1  serial line; idle high; registered.
- busy  output  1  high while a frame is in flight (START..STOP).
- frame_done  output  1  one-cycle pulse when the stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Registers:
  - shift register (8 bits)
  - parity bit
  - bit counter (3 bits, 0..7)
  - baud counter, width $clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1
- IDLE:
  - tx_out=1, tx_ready=1, busy=0.
  - On tx_valid && tx_ready, at that edge:
    - latch tx_data into the shift register
    - latch parity = ^tx_data ^ INVERT_PARITY
    - clear the baud counter
    - go to START
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
- DATA:
  - tx_out = shift[0] for CLKS_PER_BIT cycles per bit.
  - At the end of each bit, shift right and increment the bit counter.
  - After bit 7, go to PARITY.
- PARITY: tx_out = latched parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE. frame_done pulses high for exactly the cycle following that transition edge.
- tx_ready is 0 in every state except IDLE.
  - tx_valid is ignored while tx_ready=0.
  - tx_data changes after acceptance do not affect the frame in flight.
- The baud counter wraps to 0 at CLKS_PER_BIT-1 and advances the state or bit. It is never left non-zero on entry to a new state.
- Reset, applied at any time including mid-frame, at the next edge with rst_n=0:
  - state=IDLE, tx_out=1, tx_ready=0, busy=0, frame_done=0, all counters=0
  - the partial frame is abandoned; it is not resumed.
- First edge with rst_n=1 after reset: tx_ready becomes 1. A handshake cannot occur during reset.

## Timing
- Handshake accepted at edge E0:
  - from E0, tx_out=0 (start bit) through edge E0+N, where N=CLKS_PER_BIT
  - data bit i is driven from edge E0+(1+i)·N
  - parity is driven from E0+9N
  - stop is driven from E0+10N
  - at E0+11N: state=IDLE, tx_ready=1, frame_done=1 for one cycle
- Earliest next handshake is edge E0+11N+1. The back-to-back frame period is 11N+1 cycles, with a one-cycle idle-high gap between frames.
- busy rises at E0 and falls at E0+11N.
- Latency from handshake to first line transition: 1 edge (tx_out is registered).
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset, then idle with CLKS_PER_BIT=4 and INVERT_PARITY=0:
  - during reset: tx_out=1, tx_ready=0
  - first edge after release: tx_ready=1
  - line stays 1 with tx_valid=0
- Send 0xA5:
  - line sequence per 4 cycles: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1 (44 cycles)
  - frame_done pulses once at E0+44
- Send 0x07 with INVERT_PARITY=0:
  - parity bit = 1
  - repeat with INVERT_PARITY=1: parity bit = 0
- Back-to-back: hold tx_valid=1 with 0x00 then 0xFF.
  - second handshake at exactly E0+45
  - 0x00 frame parity bit = 0; 0xFF frame parity bit = 0
  - one-cycle idle-high gap between frames
- Busy-time interference: mid-frame, toggle tx_valid and change tx_data to 0x3C.
  - the frame in flight is unchanged
  - no extra handshake occurs until tx_ready=1
- Reset mid-DATA (bit 3 of 0x81):
  - next edge: tx_out=1, busy=0, no frame_done
  - a new send of 0x81 afterwards produces a complete correct frame (data 1,0,0,0,0,0,0,1, parity 0)
